// File: rtl/ifu_pkg.sv
// Shared types and constants for the IFU fetch-stall countdown timer.
package ifu_pkg;

  localparam int IFU_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } stall_state_t;

endpackage

// File: rtl/dec4bit.sv
// Gate-level 4-bit decrementer, mirror of the fetch-path incrementer:
// bit i toggles when every lower bit is 0; borrow_out flags an input of 0.
module dec4bit (
  input  logic [3:0] in,
  output logic [3:0] out,
  output logic       borrow_out
);

  logic [4:0] zero_below;

  assign zero_below[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign zero_below[i+1] = zero_below[i] & ~in[i];
    assign out[i]          = in[i] ^ zero_below[i];
  end

  assign borrow_out = zero_below[4];

endmodule

// File: rtl/ifu_stall_countdown.sv
// Fetch-stall countdown: load a stall length, count down on unheld cycles,
// then present completion on a valid/ready handshake.
module ifu_stall_countdown
  import ifu_pkg::*;
#(
  parameter int WIDTH = IFU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_count,
  output logic             load_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);

  stall_state_t     state;
  logic [WIDTH-1:0] count_dec;
  logic             borrow;

  dec4bit u_dec (
    .in        (count),
    .out       (count_dec),
    .borrow_out(borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            if (load_count == '0) begin
              state <= DONE;
              count <= '0;
            end else begin
              state <= COUNT;
              count <= load_count;
            end
          end
        end
        COUNT: begin
          // borrow only fires on an impossible zero count; finishing there
          // keeps the counter from wrapping to 15.
          if (!hold) begin
            if (count == WIDTH'(1) || borrow) begin
              state <= DONE;
              count <= '0;
            end else begin
              count <= count_dec;
            end
          end
        end
        DONE: begin
          count <= '0;
          if (done_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == COUNT);
  assign done_valid = (state == DONE);

endmodule
